// File: rtl/edge_row_cache.sv
// edge_row_cache
//   Set-associative cache of complete adjacency-matrix rows for the Dijkstra
//   datapath. It answers (from_node, to_node) edge queries over a valid/ready
//   handshake. On a miss it refills a whole row from memory, choosing the line
//   to replace in round-robin order. The response leaves as soon as the
//   requested column arrives (early restart), and the rest of the row keeps
//   streaming in behind it.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   base_address            matrix base address, sampled while reset is high
//   number_of_nodes         matrix dimension N, sampled while reset is high
//   invalidate              pulse: drop every cached row
//   query_valid/query_ready request handshake; from_node = row, to_node = column
//   resp_valid              one-cycle response strobe
//   resp_error, hit         qualify resp_valid (out-of-range / served from cache)
//   edge_value              edge weight (0 on error)
//   mem_addr, mem_read_enable   read request; both are driven to 0 when not filling
//   mem_read_ready, mem_data    read data valid strobe and data
module edge_row_cache #(
   parameter int MAX_NODES   = 16,
   parameter int INDEX_WIDTH = 4,
   parameter int VALUE_WIDTH = 8,
   parameter int MADDR_WIDTH = 16,
   parameter int MDATA_WIDTH = 16,
   parameter int NUM_ROWS    = 4,
   parameter int ELEM_BYTES  = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [MADDR_WIDTH-1:0] base_address,
   input  logic [INDEX_WIDTH-1:0] number_of_nodes,
   input  logic                   invalidate,
   input  logic                   query_valid,
   output logic                   query_ready,
   input  logic [INDEX_WIDTH-1:0] from_node,
   input  logic [INDEX_WIDTH-1:0] to_node,
   output logic                   resp_valid,
   output logic                   resp_error,
   output logic [VALUE_WIDTH-1:0] edge_value,
   output logic                   hit,
   output logic [MADDR_WIDTH-1:0] mem_addr,
   output logic                   mem_read_enable,
   input  logic                   mem_read_ready,
   input  logic [MDATA_WIDTH-1:0] mem_data
);

   localparam int PTR_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_FILL   = 2'd2;
   localparam logic [1:0] S_DRAIN  = 2'd3;

   logic [1:0]                                            state_q, state_d;
   logic [MADDR_WIDTH-1:0]                                base_q, base_d;
   logic [INDEX_WIDTH-1:0]                                nodes_q, nodes_d;
   logic [INDEX_WIDTH-1:0]                                from_q, from_d;
   logic [INDEX_WIDTH-1:0]                                to_q, to_d;
   logic [INDEX_WIDTH-1:0]                                column_q, column_d;
   logic [NUM_ROWS-1:0]                                   valid_q, valid_d;
   logic [NUM_ROWS-1:0][INDEX_WIDTH-1:0]                  tag_q, tag_d;
   logic [NUM_ROWS-1:0][MAX_NODES-1:0][VALUE_WIDTH-1:0]   line_q, line_d;
   logic [PTR_W-1:0]                                      victim_ptr_q, victim_ptr_d;
   logic [PTR_W-1:0]                                      fill_line_q, fill_line_d;
   logic                                                  inval_pend_q, inval_pend_d;
   logic                                                  early_valid_q, early_valid_d;
   logic [VALUE_WIDTH-1:0]                                early_value_q, early_value_d;

   logic                   out_of_range;
   logic                   lookup_hit;
   logic [PTR_W-1:0]       hit_line;
   logic                   free_found;
   logic [PTR_W-1:0]       free_line;
   logic [PTR_W-1:0]       victim;
   logic [VALUE_WIDTH-1:0] hit_value;
   logic [MADDR_WIDTH-1:0] elem_index;
   logic [MADDR_WIDTH-1:0] fill_addr;
   logic                   unused_mem_bits;

   // Only the low VALUE_WIDTH bits of a memory word hold the edge weight.
   assign unused_mem_bits = ^mem_data;

   // Tag match and the lowest free line, both over the current line state.
   always_comb begin
      lookup_hit = 1'b0;
      hit_line   = '0;
      free_found = 1'b0;
      free_line  = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (valid_q[i] && (tag_q[i] == from_q) && !lookup_hit) begin
            lookup_hit = 1'b1;
            hit_line   = PTR_W'(i);
         end
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_line  = PTR_W'(i);
         end
      end
   end

   assign out_of_range = (from_q >= nodes_q) || (to_q >= nodes_q);
   assign hit_value    = line_q[hit_line][to_q];
   assign victim       = free_found ? free_line : victim_ptr_q;

   // Row-major element address. All terms are truncated to MADDR_WIDTH, so
   // the address wraps modulo 2^MADDR_WIDTH.
   assign elem_index = MADDR_WIDTH'(from_q) * MADDR_WIDTH'(nodes_q) + MADDR_WIDTH'(column_q);
   assign fill_addr  = base_q + elem_index * MADDR_WIDTH'(ELEM_BYTES);

   always_comb begin
      state_d       = state_q;
      base_d        = reset ? base_address : base_q;
      nodes_d       = reset ? number_of_nodes : nodes_q;
      from_d        = from_q;
      to_d          = to_q;
      column_d      = column_q;
      valid_d       = valid_q;
      tag_d         = tag_q;
      line_d        = line_q;
      victim_ptr_d  = victim_ptr_q;
      fill_line_d   = fill_line_q;
      early_valid_d = 1'b0;
      early_value_d = '0;

      case (state_q)
         S_IDLE: begin
            if (query_valid) begin
               from_d  = from_node;
               to_d    = to_node;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (out_of_range || lookup_hit) begin
               state_d = S_IDLE;
            end else begin
               // The round-robin pointer advances on every miss, even when a
               // free line absorbs the fill.
               victim_ptr_d    = (victim_ptr_q == PTR_W'(NUM_ROWS - 1)) ? '0 : victim_ptr_q + 1'b1;
               valid_d[victim] = 1'b0;
               tag_d[victim]   = from_q;
               fill_line_d     = victim;
               column_d        = '0;
               state_d         = S_FILL;
            end
         end
         S_FILL: begin
            if (mem_read_ready) begin
               line_d[fill_line_q][column_q] = mem_data[VALUE_WIDTH-1:0];
               if (column_q == to_q) begin
                  early_valid_d = 1'b1;
                  early_value_d = mem_data[VALUE_WIDTH-1:0];
               end
               if (column_q == nodes_q - 1'b1) begin
                  valid_d[fill_line_q] = 1'b1;
                  state_d              = S_DRAIN;
               end else begin
                  column_d = column_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;   // DRAIN: the early response (if any) goes out now
      endcase

      // An invalidate seen outside IDLE waits until the current query is done.
      // Applying it on entry to IDLE (or in IDLE) also makes a same-cycle
      // accept look up an empty cache.
      inval_pend_d = inval_pend_q | invalidate;
      if ((state_q == S_IDLE || state_d == S_IDLE) && inval_pend_d) begin
         valid_d      = '0;
         inval_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         base_q        <= base_d;
         nodes_q       <= nodes_d;
         from_q        <= '0;
         to_q          <= '0;
         column_q      <= '0;
         valid_q       <= '0;
         tag_q         <= '0;
         victim_ptr_q  <= '0;
         fill_line_q   <= '0;
         inval_pend_q  <= 1'b0;
         early_valid_q <= 1'b0;
         early_value_q <= '0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         nodes_q       <= nodes_d;
         from_q        <= from_d;
         to_q          <= to_d;
         column_q      <= column_d;
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         victim_ptr_q  <= victim_ptr_d;
         fill_line_q   <= fill_line_d;
         inval_pend_q  <= inval_pend_d;
         early_valid_q <= early_valid_d;
         early_value_q <= early_value_d;
      end
   end

   // Line data needs no reset. A line's contents are only read after its
   // valid bit has been set by a complete fill.
   always_ff @(posedge clock) begin
      if (!reset) line_q <= line_d;
   end

   // A LOOKUP response and an early-restart response can never overlap:
   // early_valid_q is only set while filling, and LOOKUP follows IDLE.
   assign query_ready     = (state_q == S_IDLE);
   assign resp_error      = (state_q == S_LOOKUP) && out_of_range;
   assign hit             = (state_q == S_LOOKUP) && !out_of_range && lookup_hit;
   assign resp_valid      = resp_error || hit || early_valid_q;
   assign edge_value      = hit ? hit_value : early_value_q;
   assign mem_read_enable = (state_q == S_FILL);
   assign mem_addr        = (state_q == S_FILL) ? fill_addr : '0;

endmodule

// File: tb/tb_edge_row_cache.sv
// Self-checking bench for edge_row_cache. It compares the DUT against a
// row-level reference model: tags, a round-robin pointer and row contents
// taken from a synthetic memory.
module tb_edge_row_cache;

   localparam int NR = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] base_address;
   logic [3:0]  number_of_nodes;
   logic        invalidate;
   logic        query_valid;
   logic        query_ready;
   logic [3:0]  from_node;
   logic [3:0]  to_node;
   logic        resp_valid;
   logic        resp_error;
   logic [7:0]  edge_value;
   logic        hit;
   logic [15:0] mem_addr;
   logic        mem_read_enable;
   logic        mem_read_ready;
   logic [15:0] mem_data;
   logic [15:0] mem_seed;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit          m_valid[NR];
   int          m_tag[NR];
   logic [7:0]  m_line[NR][16];
   int          m_ptr;
   int          m_base;
   int          m_n;

   edge_row_cache #(.NUM_ROWS(NR)) dut (
      .clock(clock), .reset(reset), .base_address(base_address),
      .number_of_nodes(number_of_nodes), .invalidate(invalidate),
      .query_valid(query_valid), .query_ready(query_ready),
      .from_node(from_node), .to_node(to_node), .resp_valid(resp_valid),
      .resp_error(resp_error), .edge_value(edge_value), .hit(hit),
      .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
      .mem_read_ready(mem_read_ready), .mem_data(mem_data)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] s);
      logic [15:0] p;
      p = a * 16'h9E37;
      return p ^ s ^ {a[7:0], a[15:8]};
   endfunction

   assign mem_data = mem_word(mem_addr, mem_seed);

   function automatic logic [15:0] row_addr(input int f, input int c);
      int a;
      a = (m_base + (f * m_n + c) * 2) % 65536;
      return a[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NR; i++) m_valid[i] = 0;
   endtask

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic do_reset(input int b, input int n);
      reset = 1; base_address = b[15:0]; number_of_nodes = n[3:0];
      query_valid = 0; invalidate = 0; mem_read_ready = 0;
      step();
      chk("rst_query_ready", query_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_error", resp_error, 0);
      chk("rst_hit", hit, 0);
      chk("rst_edge_value", edge_value, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_re", mem_read_enable, 0);
      step();
      reset = 0;
      model_clear(); m_ptr = 0; m_base = b; m_n = n;
   endtask

   task automatic pulse_inval();
      invalidate = 1; step(); invalidate = 0;
      model_clear();
   endtask

   // Issue one query and follow it until the DUT returns to IDLE.
   // inval_at: -1 none, 0 with the accept, k>0 on the k-th cycle after accept.
   task automatic run_query(input int f, input int t, input int stall_first,
                            input int inval_at, input bit rand_rdy);
      int w, k, nresp, resp_k, ncap, cap_t_k, re_cycles, stalls, victim, nreads;
      bit done, exp_err, exp_hit, miss, fired, prev_rv;
      logic [31:0] exp_val;
      logic [15:0] word;
      logic [7:0]  rval, row[16];
      logic        rerr, rhit;

      w = 0;
      while (!query_ready && w < 100) begin step(); w++; end
      chk("ready_before_query", query_ready, 1);

      if (inval_at == 0) model_clear();
      exp_err = (f >= m_n) || (t >= m_n);
      exp_hit = 0; miss = 0; exp_val = 0; victim = -1;
      if (!exp_err) begin
         for (int i = 0; i < NR; i++)
            if (m_valid[i] && m_tag[i] == f && !exp_hit) begin
               exp_hit = 1; exp_val = {24'b0, m_line[i][t]};
            end
         if (!exp_hit) begin
            miss = 1;
            for (int i = NR - 1; i >= 0; i--) if (!m_valid[i]) victim = i;
            if (victim < 0) victim = m_ptr;
            m_ptr = (m_ptr + 1) % NR;
            m_valid[victim] = 0;
            for (int c = 0; c < m_n; c++) begin
               word = mem_word(row_addr(f, c), mem_seed);
               row[c] = word[7:0];
            end
            exp_val = {24'b0, row[t]};
         end
      end
      nreads = miss ? m_n : 0;

      query_valid = 1; from_node = 4'(f); to_node = 4'(t); invalidate = (inval_at == 0);
      step();
      query_valid = 0; invalidate = 0;

      k = 1; done = 0; nresp = 0; resp_k = -1; ncap = 0; cap_t_k = -100;
      re_cycles = 0; stalls = 0; fired = 0; prev_rv = 0;
      rval = 0; rerr = 0; rhit = 0;
      while (!done && k < 300) begin
         if (resp_valid) begin
            chk("resp_gap", prev_rv, 0);
            nresp++; resp_k = k; rval = edge_value; rerr = resp_error; rhit = hit;
         end
         prev_rv = resp_valid;
         if (query_ready) done = 1;
         if (!done) begin
            if (mem_read_enable) begin
               re_cycles++;
               chk("read_in_range", ncap < nreads, 1);
               if (ncap < nreads) chk("mem_addr", mem_addr, row_addr(f, ncap));
               if (ncap == 0 && stalls < stall_first) begin
                  mem_read_ready = 0; stalls++;
               end else begin
                  mem_read_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
               end
               if (mem_read_ready) begin
                  if (ncap == t) cap_t_k = k;
                  ncap++;
               end
            end else begin
               mem_read_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            invalidate = (inval_at > 0 && k == inval_at);
            if (invalidate) fired = 1;
            step();
            k++;
         end
      end
      invalidate = 0; mem_read_ready = 0;
      chk("query_done", done, 1);

      if (miss) begin
         m_valid[victim] = 1; m_tag[victim] = f;
         for (int c = 0; c < m_n; c++) m_line[victim][c] = row[c];
      end
      if (fired) model_clear();

      chk("resp_count", nresp, 1);
      chk("resp_error", rerr, exp_err);
      chk("hit", rhit, exp_hit);
      chk("edge_value", rval, exp_val);
      chk("reads", ncap, nreads);
      if (miss) chk("early_restart_cycle", resp_k, cap_t_k + 1);
      else begin
         chk("resp_latency", resp_k, 1);
         chk("no_mem_traffic", re_cycles, 0);
      end
      chk("idle_mem_re", mem_read_enable, 0);
      chk("idle_mem_addr", mem_addr, 0);
   endtask

   task automatic reset_mid_fill();
      int fmiss, fcached;
      fmiss = -1; fcached = -1;
      for (int r = 3; r >= 0; r--) begin
         bit present;
         present = 0;
         for (int i = 0; i < NR; i++) if (m_valid[i] && m_tag[i] == r) present = 1;
         if (present) fcached = r; else fmiss = r;
      end
      mem_read_ready = 1;
      query_valid = 1; from_node = 4'(fmiss); to_node = 4'd3;
      step(); query_valid = 0;      // LOOKUP
      step();                       // first read presented
      chk("mf_mem_re", mem_read_enable, 1);
      step();                       // second read presented
      step();                       // two captures done
      reset = 1;
      step();
      chk("mf_mem_re_after_reset", mem_read_enable, 0);
      chk("mf_query_ready", query_ready, 1);
      chk("mf_resp_valid", resp_valid, 0);
      chk("mf_mem_addr", mem_addr, 0);
      reset = 0; mem_read_ready = 0;
      model_clear(); m_ptr = 0;
      // a row that was cached before the reset must now miss
      if (fcached >= 0) run_query(fcached, 0, 0, -1, 0);
   endtask

   initial begin
      int nb, nn, f, t, ia;
      reset = 1; invalidate = 0; query_valid = 0; from_node = 0; to_node = 0;
      mem_read_ready = 0; base_address = 0; number_of_nodes = 0;
      mem_seed = 16'($urandom);

      // cold miss with early restart, then a hit served from the stored row
      do_reset(16'h0100, 4);
      run_query(1, 2, 0, -1, 0);
      mem_seed = 16'($urandom);
      run_query(1, 3, 0, -1, 0);

      // round-robin eviction
      do_reset(16'h0100, 4);
      run_query(0, 1, 0, -1, 0);
      run_query(1, 2, 0, -1, 0);
      run_query(2, 0, 0, -1, 0);
      run_query(1, 1, 0, -1, 0);
      run_query(0, 0, 0, -1, 0);
      run_query(2, 3, 0, -1, 0);

      // memory stall on the first read
      run_query(1, 0, 3, -1, 0);

      // out-of-range queries
      run_query(4, 0, 0, -1, 0);
      run_query(0, 4, 0, -1, 0);

      // invalidate during a fill, in IDLE, with an accept, and during a hit
      run_query(3, 1, 0, 3, 0);
      run_query(3, 2, 0, -1, 0);
      run_query(3, 0, 0, -1, 0);
      pulse_inval();
      run_query(3, 0, 0, -1, 0);
      run_query(3, 1, 0, 0, 0);
      run_query(3, 2, 0, 1, 0);
      run_query(3, 2, 0, -1, 0);

      // reset in the middle of a fill
      reset_mid_fill();

      // N = 0: everything is out of range
      do_reset(16'h0100, 0);
      run_query(0, 0, 0, -1, 0);

      // randomized phase over random base (including wrap) and size
      for (int phase = 0; phase < 3; phase++) begin
         nb = $urandom_range(0, 65535);
         nn = $urandom_range(1, 15);
         do_reset(nb, nn);
         for (int q = 0; q < 70; q++) begin
            if ($urandom_range(0, 19) == 0) pulse_inval();
            if ($urandom_range(0, 9) == 0) mem_seed = 16'($urandom);
            f  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            t  = $urandom_range(0, nn);
            ia = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1;
            run_query(f, t, $urandom_range(0, 3), ia, 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/edge_row_cache.md
Name: edge_row_cache

Overview:
- Multi-row, set-associative successor to the single-row edge cache in the Dijkstra datapath.
- Holds NUM_ROWS complete adjacency-matrix rows. Serves (from_node, to_node) edge queries through a valid/ready handshake.
- On a miss, fills a whole row from memory using round-robin replacement and early restart: the response returns as soon as the requested column arrives.
- Sits between the relaxation engine and the shared memory port. Drives memory lines with 0 when idle; it never tristates them.

Parameters:
- MAX_NODES, 16: max row length (entries per cache line).
- INDEX_WIDTH, 4: node index width.
- VALUE_WIDTH, 8: edge weight width.
- MADDR_WIDTH, 16: memory address width.
- MDATA_WIDTH, 16: memory data width (must be >= VALUE_WIDTH).
- NUM_ROWS, 4: cached rows (lines), power of two, >= 1.
- ELEM_BYTES, 2: byte stride between matrix elements.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- base_address  in  MADDR_WIDTH  matrix base; sampled while reset is high
- number_of_nodes  in  INDEX_WIDTH  N; sampled while reset is high
- invalidate  in  1  pulse: drop all cached rows
- query_valid  in  1  request present
- query_ready  out  1  request accepted when valid && ready
- from_node  in  INDEX_WIDTH  row
- to_node  in  INDEX_WIDTH  column
- resp_valid  out  1  one-cycle response strobe
- resp_error  out  1  qualifies resp_valid: query out of range
- edge_value  out  VALUE_WIDTH  edge weight
- hit  out  1  qualifies resp_valid: served without a memory access
- mem_addr  out  MADDR_WIDTH  read address
- mem_read_enable  out  1  read request
- mem_read_ready  in  1  data valid on mem_data this cycle
- mem_data  in  MDATA_WIDTH  read data

Behaviour:
- Reset (synchronous, active-high):
  - All line valid bits cleared; victim pointer = 0; state IDLE.
  - query_ready=1, resp_valid=0, resp_error=0, hit=0, edge_value=0, mem_addr=0, mem_read_enable=0.
  - Reset mid-fill abandons the fill; mem_read_enable is 0 from the next cycle.
- States: IDLE, LOOKUP, FILL, DRAIN.
- IDLE: query_ready=1. On accept (cycle T), latch from_node/to_node and go to LOOKUP.
- LOOKUP (T+1): query_ready=0.
  - Range check first: if from_node >= N or to_node >= N, pulse resp_valid with resp_error=1, edge_value=0, no memory access, go to IDLE.
  - Tag compare of from_node against all valid lines.
  - Hit: resp_valid=1, hit=1, edge_value=line[to_node], go to IDLE. Hit latency is 1 cycle; back-to-back hits sustain 1 query per 2 cycles.
  - Miss: choose the victim: lowest-index invalid line, else the line at the victim pointer, then increment the pointer modulo NUM_ROWS. Clear the victim's valid bit, set its tag to from_node, column=0, go to FILL.
- FILL:
  - mem_addr = base + (from_node*N + column)*ELEM_BYTES, computed modulo 2^MADDR_WIDTH.
  - mem_read_enable=1; addr is held stable until a cycle with mem_read_ready=1.
  - In that cycle: line[column] = mem_data[VALUE_WIDTH-1:0] and column increments. The next address is presented in the following cycle with mem_read_enable kept high.
  - Early restart: when column == to_node is captured, resp_valid=1, hit=0, edge_value=captured value on the next cycle. This happens exactly once per miss.
  - After column N-1 is captured: mem_read_enable=0, mem_addr=0, set valid, go to DRAIN.
- DRAIN: one cycle; issues the early-restart response if it is still pending; go to IDLE.
- mem_read_ready outside FILL is ignored.
- invalidate:
  - In IDLE it clears all valid bits that cycle.
  - Otherwise it is latched pending and applied on entry to IDLE; the in-progress query still completes and responds.
  - invalidate and accept in the same cycle: the invalidate applies first, so the query misses.
- N = 0: every query is out of range.
- resp_valid is never asserted for two consecutive cycles.

Test Plan:
- Cold miss, early restart. Setup: N=4, base=0x0100, ELEM_BYTES=2, mem_read_ready always 1. Query (1,2).
  - Required reads: 0x0108, 0x010A, 0x010C, 0x010E.
  - resp_valid with edge_value=mem[0x010C], hit=0, exactly once, on the cycle after the 0x010C capture; fill continues to 0x010E.
- Hit. After the cold miss, query (1,3) -> resp_valid one cycle after accept, hit=1, value from 0x010E, mem_read_enable stays 0.
- Eviction. NUM_ROWS=2. Fill rows 0, 1, then query (2,0).
  - Row 0 is evicted.
  - Query (1,1) then hits; query (0,0) misses and refetches starting at 0x0100, evicting row 1.
- Memory stall. Hold mem_read_ready=0 for 3 cycles on the first read.
  - mem_addr stays 0x0108 and mem_read_enable stays high throughout.
  - No response until the capture.
- Error and invalidate.
  - Query (4,0) with N=4 -> resp_error=1, edge_value=0, no memory traffic.
  - invalidate during a fill -> the pending query still responds; the next query to the same row misses.
- Reset mid-fill. Assert reset after the second capture.
  - The next cycle shows mem_read_enable=0, query_ready=1, all lines invalid.
